mmio_bus_ctrl: RTL and testbench

//   Parametrised memory-mapped I/O interconnect between the single-cycle CPU data port and N_CH peripherals (RAM, GPIO, counter, display).
//   - Decodes addr[31:28] against a per-channel region nibble and drives a one-hot select.
//   - Runs a req/ack handshake so slow slaves can insert wait states.
//   - Returns registered read data and a ready pulse to the CPU (feeds the CPU MIO_ready input).

---
 rtl/mmio_pkg.sv | 40 ++++
 rtl/mmio_addr_decode.sv | 36 +++
 rtl/mmio_bus_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
//   Shared definitions for the memory-mapped I/O interconnect:
//   - FSM state encoding used by mmio_bus_ctrl
//   - error read data returned on a timed-out access
//   - default region nibbles for the standard peripheral set
//   - helper that sizes the wait-state counter
//   No ports (package).
// -----------------------------------------------------------------------------
package mmio_pkg;

  // Access sequencing states: decode in IDLE, wait for the slave in ACCESS,
  // hand the single-cycle completion pulse back to the CPU in RESP.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Read data returned when a slave never answers
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  // Address-space region nibbles (addr[31:28]) of the standard peripherals
  localparam logic [3:0] REGION_RAM     = 4'h0;
  localparam logic [3:0] REGION_COUNTER = 4'hC;
  localparam logic [3:0] REGION_DISP    = 4'hE;
  localparam logic [3:0] REGION_GPIO    = 4'hF;

  // Channel 0 in the low nibble: RAM, COUNTER, DISP, GPIO
  localparam logic [15:0] DEFAULT_REGION_MAP =
    {REGION_GPIO, REGION_DISP, REGION_COUNTER, REGION_RAM};

  // Width of a counter able to reach 'limit', never narrower than 8 bits
  function automatic int wait_cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// -----------------------------------------------------------------------------
// mmio_addr_decode
//   Combinational region decoder. Compares the top address nibble against the
//   region nibble of every channel and returns a one-hot select. When several
//   channels claim the same nibble, the lowest channel index wins.
//   Ports:
//     region_i  in   4      top address nibble
//     sel_o     out  N_CH   one-hot channel select (all zero on a miss)
//     hit_o     out  1      some channel matched
// -----------------------------------------------------------------------------
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int              N_CH       = 4,
  parameter logic [N_CH*4-1:0] REGION_MAP = DEFAULT_REGION_MAP
) (
  input  logic [3:0]      region_i,
  output logic [N_CH-1:0] sel_o,
  output logic            hit_o
);

  // Scan from the highest channel down so a lower-index match overwrites a
  // higher one, which gives lowest-index priority without a separate encoder.
  always_comb begin
    sel_o = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (region_i == REGION_MAP[4*i +: 4]) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
      end
    end
  end

  assign hit_o = |sel_o;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_bus_ctrl
//   Memory-mapped I/O interconnect between the single-cycle CPU data port and
//   N_CH slave peripherals. Decodes addr[AW-1:AW-4], runs a req/ack handshake
//   so slow slaves can stretch an access, and returns registered read data with
//   a one-cycle ready pulse.
//   Optional feature: define MMIO_TIMEOUT_EN to abandon an access after
//   TIMEOUT_CYC wait cycles (returns ERR_DATA with bus_err).
//   Ports:
//     clk, rst            clock (rising edge), asynchronous active-high reset
//     cpu_req/we/addr/wdata   CPU request, sampled only in IDLE
//     cpu_rdata/ready     registered read data and completion pulse
//     bus_err             pulse with cpu_ready on unmapped or timed-out access
//     slv_sel/we/addr/wdata   one-hot select and latched request to the slaves
//     slv_rdata/slv_ack   per-channel read data and completion
// -----------------------------------------------------------------------------
module mmio_bus_ctrl
   import mmio_pkg::*;
#(
   parameter int                N_CH        = 4,
   parameter int                DW          = 32,
   parameter int                AW          = 32,
   parameter logic [N_CH*4-1:0] REGION_MAP  = DEFAULT_REGION_MAP,
   parameter int                TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [AW-1:0]        cpu_addr,
   input  logic [DW-1:0]        cpu_wdata,
   output logic [DW-1:0]        cpu_rdata,
   output logic                 cpu_ready,
   output logic                 bus_err,
   output logic [N_CH-1:0]      slv_sel,
   output logic                 slv_we,
   output logic [AW-1:0]        slv_addr,
   output logic [DW-1:0]        slv_wdata,
   input  logic [N_CH*DW-1:0]   slv_rdata,
   input  logic [N_CH-1:0]      slv_ack
);

   state_t          state_q;
   logic [N_CH-1:0] sel_q;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW-1:0]   rdata_q;
   logic            ready_q;
   logic            err_q;

   logic [N_CH-1:0] dec_sel;
   logic            dec_hit;
   logic            ack_hit;
   logic [DW-1:0]   rdata_d;

`ifdef MMIO_TIMEOUT_EN
   localparam int                WAIT_W    = wait_cnt_width(TIMEOUT_CYC);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
   logic [WAIT_W-1:0] wait_q;
`endif

   mmio_addr_decode #(
      .N_CH       (N_CH),
      .REGION_MAP (REGION_MAP)
   ) u_decode (
      .region_i (cpu_addr[AW-1:AW-4]),
      .sel_o    (dec_sel),
      .hit_o    (dec_hit)
   );

   // Only the selected channel may complete the access; because sel_q is zero
   // outside ACCESS, stray acks at any other time are masked out as well.
   assign ack_hit = |(slv_ack & sel_q);

   // AND-OR read mux over the one-hot select. Writes return zero data.
   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_q[i]) begin
            rdata_d = rdata_d | slv_rdata[DW*i +: DW];
         end
      end
      if (we_q) begin
         rdata_d = '0;
      end
   end

   // Access FSM with every output registered. ready/err default low so each
   // is a single pulse in RESP; reset drops sel/we immediately, abandoning an
   // in-flight access without a completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
         wait_q  <= '0;
`endif
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cpu_req) begin
                  addr_q  <= cpu_addr;
                  wdata_q <= cpu_wdata;
                  if (dec_hit) begin
                     sel_q   <= dec_sel;
                     we_q    <= cpu_we;
`ifdef MMIO_TIMEOUT_EN
                     wait_q  <= '0;
`endif
                     state_q <= ST_ACCESS;
                  end else begin
                     we_q    <= 1'b0;
                     rdata_q <= '0;
                     ready_q <= 1'b1;
                     err_q   <= 1'b1;
                     state_q <= ST_RESP;
                  end
               end
            end
            ST_ACCESS: begin
               if (ack_hit) begin
                  rdata_q <= rdata_d;
                  sel_q   <= '0;
                  we_q    <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= ST_RESP;
               end
`ifdef MMIO_TIMEOUT_EN
               else if (wait_q == WAIT_LAST) begin
                  rdata_q <= DW'(ERR_DATA);
                  sel_q   <= '0;
                  we_q    <= 1'b0;
                  ready_q <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
               end else begin
                  wait_q  <= wait_q + 1'b1;
               end
`endif
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_rdata = rdata_q;
   assign cpu_ready = ready_q;
   assign bus_err   = err_q;
   assign slv_sel   = sel_q;
   assign slv_we    = we_q;
   assign slv_addr  = addr_q;
   assign slv_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_bus_ctrl
//   Scoreboard bench for mmio_bus_ctrl. Requests push their expected response
//   (data, error flag, completion cycle) into a queue; a monitor pops and
//   compares whenever cpu_ready is seen. Slave channels are modelled with a
//   programmable wait count, a never-ack override and stray ack injection.
// -----------------------------------------------------------------------------
module tb_mmio_bus_ctrl;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [31:0]   cpu_addr = '0;
   logic [31:0]   cpu_wdata = '0;
   logic [31:0]   cpu_rdata;
   logic          cpu_ready;
   logic          bus_err;
   logic [3:0]    slv_sel;
   logic          slv_we;
   logic [31:0]   slv_addr;
   logic [31:0]   slv_wdata;
   logic [127:0]  slv_rdata;
   logic [3:0]    slv_ack;

   logic [3:0]    model_ack;
   logic [3:0]    never_ack = '0;
   logic [3:0]    extra_ack = '0;
   int            selcnt[4];
   int            waits[4] = '{0, 0, 0, 4};

   exp_t          sb[$];
   int            cyc = 0;
   int            total = 0;
   int            bad = 0;
   int            rdyCount = 0;

   mmio_bus_ctrl #(
      .TIMEOUT_CYC (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .bus_err   (bus_err),
      .slv_sel   (slv_sel),
      .slv_we    (slv_we),
      .slv_addr  (slv_addr),
      .slv_wdata (slv_wdata),
      .slv_rdata (slv_rdata),
      .slv_ack   (slv_ack)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Free-running cycle counter used to time-stamp expected completions
   always @(posedge clk) cyc <= cyc + 1;

   // Fixed per-channel read data
   assign slv_rdata = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h1234_5678};

   // Slave model: count how long each select has been up and ack once the
   // programmed number of wait cycles has elapsed
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) selcnt[i] <= 0;
      end else begin
         for (int i = 0; i < 4; i++) selcnt[i] <= slv_sel[i] ? selcnt[i] + 1 : 0;
      end
   end

   // Combinational ack from the slave model, plus any injected stray acks
   always_comb begin
      model_ack = '0;
      for (int i = 0; i < 4; i++) begin
         model_ack[i] = slv_sel[i] && !never_ack[i] && (selcnt[i] >= waits[i]);
      end
   end
   assign slv_ack = model_ack | extra_ack;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: flag overdue completions, then match each ready pulse against
   // the oldest expected response
   always @(negedge clk) begin
      if (!rst) begin
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            total++;
            bad++;
            $display("[TB] FAIL ready_late: no ready by cycle %0d, expected at %0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (cpu_ready) begin
            rdyCount++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_ready: ready=1 at cycle %0d with rdata %0h, expected none", cyc, cpu_rdata);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("rdata", 64'(cpu_rdata), 64'(e.rdata));
               checkOutput("bus_err", 64'(bus_err), 64'(e.err));
               checkOutput("ready_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   // Issue one single-cycle request; when expected, queue its response lat
   // cycles after the issue cycle
   task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                input bit push, input logic [31:0] expData, input logic expErr,
                                input int lat);
      exp_t e;
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      if (push) begin
         e.rdata = expData;
         e.err   = expErr;
         e.cyc   = cyc + lat;
         sb.push_back(e);
      end
      @(negedge clk);
      cpu_req = 1'b0;
   endtask

   // Directed test sequence
   initial begin
      int n;
      repeat (3) @(negedge clk);
      checkOutput("rst_sel", 64'(slv_sel), 64'h0);
      checkOutput("rst_we", 64'(slv_we), 64'h0);
      checkOutput("rst_ready", 64'(cpu_ready), 64'h0);
      checkOutput("rst_err", 64'(bus_err), 64'h0);
      checkOutput("rst_rdata", 64'(cpu_rdata), 64'h0);
      checkOutput("rst_addr", 64'(slv_addr), 64'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Read ch0 with ack tied high
      $display("[TB] read ch0");
      extra_ack = 4'b0001;
      applyStimulus(32'h0000_0010, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 2);
      checkOutput("t1_sel", 64'(slv_sel), 64'h1);
      checkOutput("t1_addr", 64'(slv_addr), 64'h10);
      checkOutput("t1_we", 64'(slv_we), 64'h0);
      @(negedge clk);
      checkOutput("t1_sel_drop", 64'(slv_sel), 64'h0);
      extra_ack = 4'b0000;
      repeat (3) @(negedge clk);

      // Write to GPIO with 4 wait cycles
      $display("[TB] write ch3 with waits");
      applyStimulus(32'hF000_0000, 1'b1, 32'hA5A5_0001, 1'b1, 32'h0, 1'b0, 6);
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("t2_sel_%0d", k), 64'(slv_sel), 64'h8);
         checkOutput($sformatf("t2_we_%0d", k), 64'(slv_we), 64'h1);
         checkOutput($sformatf("t2_wdata_%0d", k), 64'(slv_wdata), 64'hA5A5_0001);
         @(negedge clk);
      end
      checkOutput("t2_sel_drop", 64'(slv_sel), 64'h0);
      checkOutput("t2_we_drop", 64'(slv_we), 64'h0);
      repeat (3) @(negedge clk);

      // Unmapped read
      $display("[TB] unmapped read");
      applyStimulus(32'h8000_0000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
      checkOutput("t3_sel", 64'(slv_sel), 64'h0);
      repeat (3) @(negedge clk);

      // Reset in the middle of a stalled ch2 access, then a normal ch1 read
      $display("[TB] reset mid-access");
      never_ack[2] = 1'b1;
      applyStimulus(32'hE000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("t4_sel_async", 64'(slv_sel), 64'h0);
      checkOutput("t4_we_async", 64'(slv_we), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      never_ack[2] = 1'b0;
      repeat (2) @(negedge clk);
      applyStimulus(32'hC000_0004, 1'b0, 32'h0, 1'b1, 32'h1111_0001, 1'b0, 2);
      repeat (4) @(negedge clk);

      // Slave that never acks
      $display("[TB] stalled slave");
      never_ack[3] = 1'b1;
`ifdef MMIO_TIMEOUT_EN
      applyStimulus(32'hF000_0008, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 9);
      repeat (12) @(negedge clk);
      checkOutput("t5_sel_drop", 64'(slv_sel), 64'h0);
      never_ack[3] = 1'b0;
`else
      applyStimulus(32'hF000_0008, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
      repeat (30) @(negedge clk);
      checkOutput("t5_sel_held", 64'(slv_sel), 64'h8);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      never_ack[3] = 1'b0;
`endif
      repeat (3) @(negedge clk);

      // Held request to ch1 with stray ch0 acks: accepted on the 1st, 4th and
      // 7th sampling edges, the 9th edge falls in RESP
      $display("[TB] back-to-back ch1");
      @(negedge clk);
      rdyCount  = 0;
      n         = cyc;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 32'hC000_0100;
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         e.rdata = 32'h1111_0001;
         e.err   = 1'b0;
         e.cyc   = n + 2 + 3 * k;
         sb.push_back(e);
      end
      for (int k = 0; k < 9; k++) begin
         extra_ack[0] = ~extra_ack[0];
         @(negedge clk);
      end
      cpu_req   = 1'b0;
      extra_ack = 4'b0000;
      repeat (5) @(negedge clk);
      checkOutput("t6_ready_count", 64'(rdyCount), 64'd3);

      repeat (3) @(negedge clk);
      checkOutput("sb_empty", 64'(sb.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
